// File: rtl/spi_byte_sequencer.sv
// Byte FIFOs around a launcher for spi_master: enable 3 cycles after an idle write, RX head 2 edges after done.
// Writes stall on TX full, launches stall on RX full; SPI_SEQ_TIMEOUT_EN adds a sticky WAIT_DONE watchdog.

module spi_seq_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_dat_i,
    input  logic       pop_i,
    output logic       head_vld_o,
    output logic [7:0] head_dat_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic        head_vld_q, head_vld_d;
    logic [7:0]  head_q;

    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign head_vld_o = head_vld_q;
    assign head_dat_o = head_q;

    // The head register looks at pointers from before this edge's push, so a write into an
    // empty FIFO surfaces one edge later while a pop with data behind it refills at once.
    assign rd_ptr_d   = (pop_i && head_vld_q) ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    assign head_vld_d = (rd_ptr_d != wr_ptr_q);

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_vld_q <= 1'b0;
            head_q     <= 8'h00;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            rd_ptr_q   <= rd_ptr_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_vld_d ? mem_q[rd_ptr_d[AW-1:0]] : 8'h00;
        end
    end
endmodule

module spi_byte_sequencer #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       m_tx_enable,
    output logic [7:0] m_tx_data,
    input  logic       m_done,
    input  logic [7:0] m_rx_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, CAPTURE} state_t;

    state_t     state_q, state_d;
    logic [7:0] tx_dat_q, tx_dat_d, rx_dat_q, rx_dat_d;
    logic       rdy_q;
    logic       tx_push, tx_pop, tx_head_vld, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full, rx_empty_unused;
    logic       to_hit, to_fire;

    assign wr_ready  = rdy_q && !tx_full;
    assign tx_push   = wr_valid && wr_ready;
    assign m_tx_data = tx_dat_q;
    assign busy      = (state_q != IDLE) || !tx_empty;

    spi_seq_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (tx_push),
        .push_dat_i (wr_data),
        .pop_i      (tx_pop),
        .head_vld_o (tx_head_vld),
        .head_dat_o (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    spi_seq_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rx_push),
        .push_dat_i (rx_dat_q),
        .pop_i      (rd_ready),
        .head_vld_o (rd_valid),
        .head_dat_o (rd_data),
        .full_o     (rx_full),
        .empty_o    (rx_empty_unused)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            tx_dat_q <= 8'h00;
            rx_dat_q <= 8'h00;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_dat_q <= tx_dat_d;
            rx_dat_q <= rx_dat_d;
            rdy_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_dat_d    = tx_dat_q;
        rx_dat_d    = rx_dat_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        m_tx_enable = 1'b0;
        to_fire     = 1'b0;
        case (state_q)
            // A launch needs a free RX slot so the reply always has somewhere to land.
            IDLE:      if (tx_head_vld && !rx_full) state_d = LOAD;
            LOAD: begin
                tx_pop   = 1'b1;
                tx_dat_d = tx_head;
                state_d  = START;
            end
            START: begin
                m_tx_enable = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_done) begin
                    rx_dat_d = m_rx_data;
                    state_d  = CAPTURE;
                end else if (to_hit) begin
                    to_fire = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                rx_push = 1'b1;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] to_cnt_q;
    logic          err_q;

    assign to_hit      = (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == WAIT_DONE) ? to_cnt_q + CW'(1) : '0;
            if (to_fire) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign to_hit      = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = err_clr ^ to_fire ^ (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: stepwise master/consumer model, vector table, corner sequences, random traffic.
module tb_spi_byte_sequencer;
    localparam int         DEPTH = 8;
    localparam logic [7:0] XK    = 8'h99;

    logic       clk = 1'b0, reset = 1'b0;
    logic       wr_valid = 1'b0, rd_ready = 1'b0, m_done = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00, m_rx_data = 8'h00;
    logic       wr_ready, m_tx_enable, rd_valid, busy, err_timeout;
    logic [7:0] m_tx_data, rd_data;

    always #5 clk = ~clk;

    spi_byte_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .m_tx_enable(m_tx_enable), .m_tx_data(m_tx_data), .m_done(m_done), .m_rx_data(m_rx_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    int n_checks = 0, n_fail = 0;
    int stepcnt = 0, done_step = -100, last_en = -100, enables = 0, outstanding = 0, cd = 0, lat = 2;
    bit respond = 0, rand_lat = 0, stray = 0;
    logic [7:0] stray_dat = 8'h00;
    logic [7:0] acc_q[$], txlog[$], rxlog[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One clock: log handshakes about to happen, advance, then act as master for the next edge.
    task automatic step();
        if (reset && wr_valid && wr_ready) acc_q.push_back(wr_data);
        if (reset && rd_valid && rd_ready) begin
            rxlog.push_back(rd_data);
            outstanding--;
        end
        @(posedge clk); #1;
        stepcnt++;
        m_done = 1'b0;
        if (m_tx_enable) begin
            check("en_spacing", 32'(stepcnt - last_en >= 4), 1);
            last_en = stepcnt;
            enables++;
            outstanding++;
            check("rx_slot_reserved", 32'(outstanding <= DEPTH), 1);
            txlog.push_back(m_tx_data);
            if (respond) cd = rand_lat ? int'($urandom_range(1, 6)) : lat;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                m_done    = 1'b1;
                m_rx_data = m_tx_data ^ XK;
                done_step = stepcnt + 1;
            end
        end
        if (stray) begin
            m_done    = 1'b1;
            m_rx_data = stray_dat;
            done_step = stepcnt + 1;
            stray     = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_m_tx_enable"}, m_tx_enable, 0);
        check({tag, "_m_tx_data"}, m_tx_data, 8'h00);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 8'h00);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
        respond = 0; rand_lat = 0; stray = 0; cd = 0;
        step(); step();
        chk_reset("reset");
        reset = 1'b1;
        acc_q.delete(); txlog.delete(); rxlog.delete();
        outstanding = 0; last_en = -100;
        step();
        check("post_reset_wr_ready", wr_ready, 1);
    endtask

    task automatic wait_en(input int budget);
        int n = 0;
        while (!m_tx_enable && n < budget) begin step(); n++; end
        check("wait_enable", m_tx_enable, 1);
    endtask

    task automatic drain_cmp(input string tag, input int exp_n);
        check({tag, "_tx_count"}, txlog.size(), exp_n);
        check({tag, "_rx_count"}, rxlog.size(), exp_n);
        for (int i = 0; i < exp_n && i < txlog.size() && i < rxlog.size() && i < acc_q.size(); i++) begin
            check({tag, "_tx_order"}, txlog[i], acc_q[i]);
            check({tag, "_rx_order"}, rxlog[i], acc_q[i] ^ XK);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         lat;
        logic [7:0] exp_rx;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   n, e0;
        vecs[0] = '{8'h3C, 20, 8'hA5};
        vecs[1] = '{8'h00, 1,  8'h99};
        vecs[2] = '{8'hFF, 3,  8'h66};
        vecs[3] = '{8'h5A, 7,  8'hC3};

        do_reset();

        // Single transfers: launch latency, one-cycle enable, RX latency and data.
        for (int i = 0; i < 4; i++) begin
            respond = 1; lat = vecs[i].lat;
            wr_data = vecs[i].d; wr_valid = 1'b1;
            step();
            wr_valid = 1'b0;
            n = 0;
            while (!m_tx_enable && n < 20) begin step(); n++; end
            check("t1_launch_latency", n, 3);
            check("t1_m_tx_data", m_tx_data, vecs[i].d);
            step();
            check("t1_enable_one_cycle", m_tx_enable, 0);
            n = 0;
            while (!rd_valid && n < 100) begin step(); n++; end
            check("t1_rd_valid", rd_valid, 1);
            check("t1_rx_latency", stepcnt - done_step, 2);
            check("t1_rd_data", rd_data, vecs[i].exp_rx);
            rd_ready = 1'b1; step(); rd_ready = 1'b0;
            check("t1_rd_popped", rd_valid, 0);
            check("t1_not_busy", busy, 0);
        end

        // Stray done while idle.
        e0 = enables;
        stray_dat = 8'h42; stray = 1;
        step();
        repeat (5) step();
        check("t6_no_rx_push", rd_valid, 0);
        check("t6_not_busy", busy, 0);
        check("t6_no_launch", enables - e0, 0);

        // RX full holds back the ninth transfer until one entry is read.
        do_reset();
        respond = 1; lat = 2; e0 = enables;
        for (int i = 1; i <= 9; i++) begin
            wr_data = 8'(i); wr_valid = 1'b1; step();
        end
        wr_valid = 1'b0;
        repeat (150) step();
        check("t2_accepted", acc_q.size(), 9);
        check("t2_eight_launched", enables - e0, 8);
        check("t2_rd_valid", rd_valid, 1);
        check("t2_busy_queued", busy, 1);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        repeat (40) step();
        check("t2_ninth_launched", enables - e0, 9);
        rd_ready = 1'b1;
        repeat (40) step();
        rd_ready = 1'b0;
        check("t2_rx_empty", rd_valid, 0);
        drain_cmp("t2", 9);

        // TX full with master stalled; blocked write during the pop edge.
        do_reset();
        e0 = enables;
        for (int i = 1; i <= 9; i++) begin
            wr_data = 8'(i); wr_valid = 1'b1; step();
        end
        wr_valid = 1'b0;
        repeat (5) step();
        check("t3_accepted", acc_q.size(), 9);
        check("t3_tx_full", wr_ready, 0);
        check("t3_one_launch", enables - e0, 1);
        wr_data = 8'h0A; wr_valid = 1'b1;
        repeat (3) step();
        check("t3_full_blocks", acc_q.size(), 9);
        respond = 1; lat = 2;
        stray_dat = 8'h01 ^ XK; stray = 1;
        step();
        n = 0;
        while (!wr_ready && n < 10) begin step(); n++; end
        check("t3_ready_after_pop", n, 4);
        check("t3_no_write_on_pop_edge", acc_q.size(), 9);
        step();
        wr_valid = 1'b0;
        check("t3_write_after_pop", acc_q.size(), 10);
        rd_ready = 1'b1;
        repeat (120) step();
        rd_ready = 1'b0;
        drain_cmp("t3", 10);

        // Reset while waiting for done; late done afterwards is ignored.
        do_reset();
        wr_valid = 1'b1; wr_data = 8'h77; step();
        wr_data = 8'h78; step();
        wr_valid = 1'b0;
        wait_en(20);
        repeat (3) step();
        check("t4_busy_before", busy, 1);
        do_reset();
        e0 = enables;
        stray_dat = 8'hEE; stray = 1;
        step();
        repeat (6) step();
        check("t4_no_rx_push", rd_valid, 0);
        check("t4_rd_data", rd_data, 8'h00);
        check("t4_not_busy", busy, 0);
        check("t4_queue_dropped", enables - e0, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
        do_reset();
        wr_valid = 1'b1; wr_data = 8'h11; step();
        wr_data = 8'h22; step();
        wr_valid = 1'b0;
        wait_en(20);
        check("t5_first_byte", m_tx_data, 8'h11);
        repeat (16) step();
        check("t5_err_not_yet", err_timeout, 0);
        step();
        check("t5_err_set", err_timeout, 1);
        check("t5_no_rx", rd_valid, 0);
        respond = 1; lat = 3;
        wait_en(20);
        check("t5_next_byte", m_tx_data, 8'h22);
        n = 0;
        while (!rd_valid && n < 50) begin step(); n++; end
        check("t5_rd_data", rd_data, 8'hBB);
        check("t5_err_sticky", err_timeout, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("t5_err_cleared", err_timeout, 0);
`else
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("err_tied_low", err_timeout, 0);
`endif

        // Random traffic against the queue model.
        do_reset();
        respond = 1; rand_lat = 1;
        for (int c = 0; c < 400; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        n = 0;
        while ((busy || rd_valid || cd > 0) && n < 3000) begin step(); n++; end
        repeat (4) step();
        check("rand_drained", 32'(busy || rd_valid), 0);
        drain_cmp("rand", acc_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
